pipeline_perf_counter: RTL and testbench
========================================

# pipeline_perf_counter

Event-counting block inside `CPU` that tallies cycles, load-use stalls, branch flushes and retired instructions while the pipeline runs. It is fed by the hazard detection unit, the branch/flush logic and the MEM/WB pipeline register. The bench reads it through a snapshot-and-read port, replacing ad-hoc bench-side stall/flush counting with a single in-design source of truth.

## Interface
- `WIDTH`, 32, width of each counter and of `rd_data_o`.
- `clk_i`  input  1  clock; all state changes on the rising edge.
- `rst_i`  input  1  reset, asynchronous, active-low.
- `start_i`  input  1  CPU start, the same signal driving `CPU.start_i`.
- `stall_i`  input  1  hazard unit stall request.
- `branch_i`  input  1  control unit branch decode in ID.
- `flush_i`  input  1  IF/ID flush from a taken branch.
- `retire_i`  input  1  MEM/WB holds a valid, non-bubble instruction this cycle.
- `clear_i`  input  1  synchronous clear of live counters and overflow flags.
- `snap_i`  input  1  copy all live counters into shadow registers.
- `rd_req_i`  input  1  read request.
- `rd_sel_i`  input  2  counter select: 0 cycles, 1 stalls, 2 flushes, 3 retired.
- `rd_valid_o`  output  1  one-cycle pulse marking valid `rd_data_o`.
- `rd_data_o`  output  WIDTH  shadow value of the selected counter.
- `ovf_o`  output  4  sticky saturation flags, bit n for counter n.
- `run_o`  output  1  high while the FSM is in RUN.

## Operation
- FSM has two states, IDLE and RUN. Reset enters IDLE. IDLE moves to RUN when `start_i`=1. RUN moves to IDLE when `start_i`=0. Counting happens only in RUN. The state register is also the `run_o` register.
- Per-cycle increments in RUN:
  - cycles: +1 every cycle.
  - stalls: +1 when `stall_i` && !`branch_i`.
  - flushes: +1 when `flush_i`.
  - retired: +1 when `retire_i`.
- Several counters may increment in the same cycle. Each counter is independent.
- Saturation: a counter at 2^WIDTH−1 holds its value and never wraps. An increment attempted at the maximum sets the matching `ovf_o` bit, which stays set until `clear_i` or reset.
- `clear_i` zeroes the live counters and `ovf_o`. Clear has priority over increments in the same cycle, so the result is 0, not 1. Clear does not touch the shadow registers or the FSM.
- `snap_i` loads shadow[n] ← live[n] with the pre-clear, pre-increment values of that cycle. It works in either FSM state.
- Read: when `rd_req_i`=1 at edge k, `rd_data_o` = shadow[`rd_sel_i`] and `rd_valid_o`=1 after edge k. `rd_valid_o` is held 1 for exactly one cycle unless another request follows. Back-to-back requests are accepted every cycle.
- A read in the same cycle as `snap_i` returns the newly captured value, i.e. the next-state value of shadow.
- When `rd_req_i`=0, `rd_valid_o`=0 and `rd_data_o` holds its last value.

## Timing
- Reset values: FSM IDLE, `run_o`=0, all live and shadow counters 0, `ovf_o`=0, `rd_valid_o`=0, `rd_data_o`=0.
- Reset asserted mid-count clears everything immediately, without waiting for a clock edge. The first increment after release happens at the first edge with the FSM in RUN.
- `start_i` rising before edge k: the FSM reaches RUN at edge k. The first cycle count is added at edge k+1, so the counted cycles equal the number of edges the FSM spends in RUN.
- Event inputs are sampled at edge k and reflected in live counters after edge k. A snapshot at edge k+1 sees them.
- Read latency is 1 cycle from request to data. Snapshot-to-readable latency is 0 extra cycles.

## Test plan
- Reset, then `start_i`=1 for 64 edges, then `snap_i`, then read sel 0 → `rd_data_o`=64 with a single `rd_valid_o` pulse. `run_o` is 0 before start and 1 after start.
- Drive `stall_i`=1 for 5 cycles, 2 of which also have `branch_i`=1, plus 3 `flush_i` pulses and 7 `retire_i` pulses, then snapshot → stalls=3, flushes=3, retired=7.
- Apply `clear_i` and `stall_i` together in the same cycle, then snapshot → stalls=0. Snapshot and clear together → shadow holds the pre-clear values and live counters read 0 at the next snapshot.
- `WIDTH`=4: run 20 cycles → cycles saturates at 15 and `ovf_o[0]`=1. `clear_i` → `ovf_o`=0 and the count restarts from 0.
- Drop `start_i` for 10 cycles mid-run, then raise it again → the cycle count excludes those 10 cycles and events during IDLE are ignored.
- Pulse `rst_i` low between edges mid-run → all outputs read 0 immediately, before the next edge. Back-to-back reads of sel 0,1,2,3 → four consecutive valid pulses with the matching values.

Source files
------------

// File: rtl/pipeline_perf_counter.sv
// Pipeline event counters: cycles, load-use stalls, flushes, retires.
// Live counters saturate; snapshot copies them to shadows for reading.
module pipeline_perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             clear_i,
  input  logic             snap_i,
  input  logic             rd_req_i,
  input  logic [1:0]       rd_sel_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [3:0]       ovf_o,
  output logic             run_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [3:0][WIDTH-1:0] live_q, live_d;
  logic [3:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [3:0]            ovf_q, ovf_d;
  logic [3:0]            inc;
  logic                  rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN:  if (!start_i) state_d = IDLE;
    endcase
  end

  // A branch decode in ID masks the stall so it is not charged as load-use.
  always_comb begin
    inc = '0;
    if (state_q == RUN) begin
      inc = {retire_i, flush_i, stall_i & ~branch_i, 1'b1};
    end
  end

  always_comb begin
    live_d = live_q;
    ovf_d  = ovf_q;
    for (int n = 0; n < 4; n++) begin
      if (clear_i) begin
        live_d[n] = '0;
        ovf_d[n]  = 1'b0;
      end else if (inc[n]) begin
        if (&live_q[n]) begin
          ovf_d[n] = 1'b1;
        end else begin
          live_d[n] = live_q[n] + WIDTH'(1);
        end
      end
    end
  end

  // Reads see the shadow as it will be after this edge.
  always_comb begin
    shadow_d   = snap_i ? live_q : shadow_q;
    rd_valid_d = rd_req_i;
    rd_data_d  = rd_req_i ? shadow_d[rd_sel_i] : rd_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      live_q     <= '0;
      shadow_q   <= '0;
      ovf_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      shadow_q   <= shadow_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign run_o      = (state_q == RUN);
  assign ovf_o      = ovf_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_pipeline_perf_counter.sv
// Bench for pipeline_perf_counter: WIDTH=32 and WIDTH=4 instances
// share stimulus and are checked against an integer event model.
module tb_pipeline_perf_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 0, stall = 0, branch = 0, flush = 0;
  logic retire = 0, clear = 0, snap = 0, rd_req = 0;
  logic [1:0] sel = '0;

  logic        valid32, run32;
  logic [31:0] data32;
  logic [3:0]  ovf32;
  logic        valid4, run4;
  logic [3:0]  data4;
  logic [3:0]  ovf4;

  int checks = 0;
  int errors = 0;

  longint live[2][4];
  longint sh[2][4];
  longint edata[2];
  bit [3:0] movf[2];
  bit mrun, mvalid;

  pipeline_perf_counter #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .stall_i(stall), .branch_i(branch), .flush_i(flush),
    .retire_i(retire), .clear_i(clear), .snap_i(snap),
    .rd_req_i(rd_req), .rd_sel_i(sel),
    .rd_valid_o(valid32), .rd_data_o(data32),
    .ovf_o(ovf32), .run_o(run32)
  );

  pipeline_perf_counter #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .stall_i(stall), .branch_i(branch), .flush_i(flush),
    .retire_i(retire), .clear_i(clear), .snap_i(snap),
    .rd_req_i(rd_req), .rd_sel_i(sel),
    .rd_valid_o(valid4), .rd_data_o(data4),
    .ovf_o(ovf4), .run_o(run4)
  );

  always #5 clk = ~clk;

  function automatic longint mx(int d);
    return (d == 0) ? 64'hFFFF_FFFF : 64'd15;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 4; n++) begin
        live[d][n] = 0;
        sh[d][n] = 0;
      end
      edata[d] = 0;
      movf[d] = '0;
    end
    mrun = 0;
    mvalid = 0;
  endfunction

  function automatic void model_edge();
    bit ev[4];
    ev[0] = mrun;
    ev[1] = mrun && stall && !branch;
    ev[2] = mrun && flush;
    ev[3] = mrun && retire;
    for (int d = 0; d < 2; d++) begin
      if (snap)
        for (int n = 0; n < 4; n++) sh[d][n] = live[d][n];
      for (int n = 0; n < 4; n++) begin
        if (clear) begin
          live[d][n] = 0;
          movf[d][n] = 0;
        end else if (ev[n]) begin
          if (live[d][n] == mx(d)) movf[d][n] = 1;
          else live[d][n]++;
        end
      end
      if (rd_req) edata[d] = sh[d][sel];
    end
    mvalid = rd_req;
    mrun = start;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    stall = 0; branch = 0; flush = 0; retire = 0;
    clear = 0; snap = 0; rd_req = 0;
  endtask

  task automatic rand_events();
    stall  = 1'($urandom_range(0, 1));
    branch = 1'($urandom_range(0, 3) == 0);
    flush  = 1'($urandom_range(0, 2) == 0);
    retire = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst = 0;
    quiet();
    start = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (run32 !== 1'b0 || run4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_run: got %b/%b exp 0", run32, run4);
    end
    checks++;
    if (valid32 !== 1'b0 || data32 !== 32'd0) begin
      errors++;
      $display("FAIL reset_rd: valid %b data %0d exp 0", valid32, data32);
    end
    checks++;
    if (ovf32 !== 4'd0 || ovf4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_ovf: got %h/%h exp 0", ovf32, ovf4);
    end
    #3 rst = 1;
    tick();
    checks++;
    if (run32 !== 1'b0) begin
      errors++;
      $display("FAIL run_before_start: got %b exp 0", run32);
    end
  endtask

  task automatic test_cycles();
    start = 1;
    tick();
    checks++;
    if (run32 !== 1'b1 || run4 !== 1'b1) begin
      errors++;
      $display("FAIL run_after_start: got %b/%b exp 1", run32, run4);
    end
    repeat (64) tick();
    snap = 1; rd_req = 1; sel = 0;
    tick();
    snap = 0; rd_req = 0;
    checks++;
    if (valid32 !== 1'b1 || data32 !== 32'd64) begin
      errors++;
      $display("FAIL cycles64: valid %b data %0d exp 1/64", valid32, data32);
    end
    checks++;
    if (data4 !== 4'd15 || ovf4 !== 4'b0001) begin
      errors++;
      $display("FAIL cycles_w4: data %0d ovf %b exp 15/0001", data4, ovf4);
    end
    tick();
    checks++;
    if (valid32 !== 1'b0 || data32 !== 32'd64) begin
      errors++;
      $display("FAIL single_pulse: valid %b data %0d exp 0/64", valid32, data32);
    end
  endtask

  task automatic test_events();
    int exp_v[4] = '{0, 3, 3, 7};
    clear = 1;
    tick();
    clear = 0;
    for (int i = 0; i < 7; i++) begin
      stall  = (i < 5);
      branch = (i < 2);
      flush  = (i == 1 || i == 3 || i == 5);
      retire = 1;
      tick();
    end
    quiet();
    snap = 1; rd_req = 1;
    for (int s = 1; s < 4; s++) begin
      sel = 2'(s);
      tick();
      snap = 0;
      checks++;
      if (data32 !== 32'(exp_v[s]) || data4 !== 4'(exp_v[s])) begin
        errors++;
        $display("FAIL events_sel%0d: got %0d/%0d exp %0d",
                 s, data32, data4, exp_v[s]);
      end
    end
    rd_req = 0;
  endtask

  task automatic test_clear_priority();
    clear = 1; stall = 1;
    tick();
    clear = 0; stall = 0;
    snap = 1; rd_req = 1; sel = 1;
    tick();
    quiet();
    checks++;
    if (data32 !== 32'd0) begin
      errors++;
      $display("FAIL clear_vs_inc: got %0d exp 0", data32);
    end
    stall = 1;
    repeat (4) tick();
    stall = 0;
    snap = 1; clear = 1; rd_req = 1; sel = 1;
    tick();
    clear = 0;
    checks++;
    if (data32 !== 32'd4) begin
      errors++;
      $display("FAIL snap_pre_clear: got %0d exp 4", data32);
    end
    tick();
    quiet();
    checks++;
    if (data32 !== 32'd0 || ovf32 !== 4'd0) begin
      errors++;
      $display("FAIL live_after_clear: got %0d ovf %h exp 0", data32, ovf32);
    end
  endtask

  task automatic test_saturation();
    clear = 1;
    tick();
    clear = 0;
    repeat (20) tick();
    snap = 1; rd_req = 1; sel = 0;
    tick();
    quiet();
    checks++;
    if (data4 !== 4'd15 || ovf4 !== 4'b0001) begin
      errors++;
      $display("FAIL sat_w4: data %0d ovf %b exp 15/0001", data4, ovf4);
    end
    checks++;
    if (data32 !== 32'd20) begin
      errors++;
      $display("FAIL sat_w32: got %0d exp 20", data32);
    end
    clear = 1;
    tick();
    clear = 0;
    checks++;
    if (ovf4 !== 4'd0) begin
      errors++;
      $display("FAIL ovf_clear: got %b exp 0000", ovf4);
    end
    repeat (3) tick();
    snap = 1; rd_req = 1; sel = 0;
    tick();
    quiet();
    checks++;
    if (data4 !== 4'd3) begin
      errors++;
      $display("FAIL sat_restart: got %0d exp 3", data4);
    end
  endtask

  task automatic test_idle_gap();
    clear = 1;
    tick();
    clear = 0;
    repeat (6) begin rand_events(); tick(); end
    start = 0;
    repeat (10) begin rand_events(); tick(); end
    checks++;
    if (run32 !== 1'b0) begin
      errors++;
      $display("FAIL idle_run: got %b exp 0", run32);
    end
    start = 1;
    repeat (6) begin rand_events(); tick(); end
    quiet();
    snap = 1; rd_req = 1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      snap = 0;
      checks++;
      if (data32 !== 32'(edata[0])) begin
        errors++;
        $display("FAIL idle_gap_sel%0d: got %0d exp %0d", s, data32, edata[0]);
      end
    end
    rd_req = 0;
    checks++;
    if (sh[0][0] != 12 || data32 === 32'hx) begin
      errors++;
      $display("FAIL idle_gap_cycles: model %0d exp 12", sh[0][0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      start  = 1'($urandom_range(0, 9) != 0);
      rand_events();
      clear  = 1'($urandom_range(0, 40) == 0);
      snap   = 1'($urandom_range(0, 3) == 0);
      rd_req = 1'($urandom_range(0, 1));
      sel    = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (valid32 !== mvalid || valid4 !== mvalid) begin
        errors++;
        $display("FAIL rnd_valid@%0d: got %b/%b exp %b",
                 i, valid32, valid4, mvalid);
      end
      checks++;
      if (data32 !== 32'(edata[0]) || data4 !== 4'(edata[1])) begin
        errors++;
        $display("FAIL rnd_data@%0d: got %0d/%0d exp %0d/%0d",
                 i, data32, data4, edata[0], edata[1]);
      end
      checks++;
      if (ovf32 !== movf[0] || ovf4 !== movf[1]) begin
        errors++;
        $display("FAIL rnd_ovf@%0d: got %b/%b exp %b/%b",
                 i, ovf32, ovf4, movf[0], movf[1]);
      end
      checks++;
      if (run32 !== mrun) begin
        errors++;
        $display("FAIL rnd_run@%0d: got %b exp %b", i, run32, mrun);
      end
    end
    quiet();
    start = 1;
  endtask

  task automatic test_async_reset();
    quiet();
    start = 1; stall = 1; retire = 1;
    repeat (5) tick();
    snap = 1; rd_req = 1; sel = 0;
    tick();
    snap = 0;
    #2 rst = 0;
    #1;
    model_reset();
    checks++;
    if (run32 !== 1'b0 || valid32 !== 1'b0 || data32 !== 32'd0) begin
      errors++;
      $display("FAIL async_rst: run %b valid %b data %0d exp 0",
               run32, valid32, data32);
    end
    checks++;
    if (ovf4 !== 4'd0 || data4 !== 4'd0 || run4 !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_w4: ovf %b data %0d exp 0", ovf4, data4);
    end
    #2 rst = 1;
    quiet();
    snap = 1; rd_req = 1; sel = 3;
    tick();
    quiet();
    checks++;
    if (valid32 !== 1'b1 || data32 !== 32'd0) begin
      errors++;
      $display("FAIL rst_shadow: valid %b data %0d exp 1/0", valid32, data32);
    end
  endtask

  task automatic test_back_to_back();
    repeat (25) begin rand_events(); tick(); end
    quiet();
    snap = 1; rd_req = 1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      snap = 0;
      checks++;
      if (valid32 !== 1'b1 || data32 !== 32'(edata[0])) begin
        errors++;
        $display("FAIL b2b_sel%0d: valid %b data %0d exp 1/%0d",
                 s, valid32, data32, edata[0]);
      end
      checks++;
      if (data4 !== 4'(edata[1])) begin
        errors++;
        $display("FAIL b2b_w4_sel%0d: got %0d exp %0d", s, data4, edata[1]);
      end
    end
    rd_req = 0;
    tick();
    checks++;
    if (valid32 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: valid %b exp 0", valid32);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cycles();
    test_events();
    test_clear_priority();
    test_saturation();
    test_idle_gap();
    test_random();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
